// File: rtl/mac_rx_frame_ctrl.sv
// rtl/mac_rx_frame_ctrl.sv - receive frame controller: FCS/DA/length check, ring buffer write, descriptor publish
//
// Consumes the post-SFD byte stream from the RGMII RX front-end, writes each
// frame speculatively into a byte-wide ring buffer and either commits it
// (publishing one descriptor) or rolls the write pointer back so the buffer
// only ever holds complete, good frames.
//
// Ports
//   rx_clk, rst_n                clock, asynchronous active-low reset
//   byte_vld, byte_data          post-SFD data bytes
//   sof, eof                     frame start / end pulses
//   promisc, accept_mcast        destination address filter controls
//   rd_ptr                       consumer read pointer (limits free space)
//   wr_en, wr_addr, wr_data      registered ring buffer write port
//   desc_vld, desc_rdy           descriptor handshake
//   desc_start, desc_len         first byte address, length without FCS
//   ok_cnt, crc_err_cnt, drop_cnt  saturating event counters

module mac_rx_frame_ctrl #(
    parameter int          ADDR_W   = 11,
    parameter logic [47:0] MAC_ADDR = 48'h02_00_00_00_00_01,
    parameter int          MIN_LEN  = 64,
    parameter int          MAX_LEN  = 1518
) (
    input  logic              rx_clk,
    input  logic              rst_n,
    input  logic              byte_vld,
    input  logic [7:0]        byte_data,
    input  logic              sof,
    input  logic              eof,
    input  logic              promisc,
    input  logic              accept_mcast,
    input  logic [ADDR_W-1:0] rd_ptr,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              desc_vld,
    input  logic              desc_rdy,
    output logic [ADDR_W-1:0] desc_start,
    output logic [15:0]       desc_len,
    output logic [15:0]       ok_cnt,
    output logic [15:0]       crc_err_cnt,
    output logic [15:0]       drop_cnt
);

    localparam logic [31:0]       CRC_POLY    = 32'hEDB8_8320;
    localparam logic [31:0]       CRC_RESIDUE = 32'hDEBB_20E3;
    localparam logic [15:0]       MIN_LEN_W   = 16'(MIN_LEN);
    localparam logic [15:0]       MAX_LEN_W   = 16'(MAX_LEN);
    localparam logic [ADDR_W-1:0] PTR_ONE     = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0] cptr_q, wptr_q;
    logic [15:0]       cnt_q;
    logic [31:0]       crc_q;
    logic [47:0]       da_q;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [7:0]        wr_data_q;
    logic              desc_vld_q;
    logic [ADDR_W-1:0] desc_start_q;
    logic [15:0]       desc_len_q;
    logic [15:0]       ok_cnt_q, crc_err_cnt_q, drop_cnt_q;

    // Decoded per-cycle actions
    logic do_start, do_write, do_eval, do_abandon;
    logic overflow;
    logic [ADDR_W-1:0] free_space;
    logic frame_good, filter_pass, slot_free;
    logic do_commit, do_rollback, crc_inc, drop_inc;

    function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] c;
        c = crc ^ {24'd0, d};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // One slot is always kept empty so wptr == rd_ptr unambiguously means empty.
    assign free_space = rd_ptr - wptr_q - PTR_ONE;
    // cnt_q already at MAX_LEN means this byte would make the frame too long.
    assign overflow   = (cnt_q >= MAX_LEN_W) || (free_space == '0);

    // Checking the raw register against the residue avoids a separate FCS compare.
    assign frame_good  = (crc_q == CRC_RESIDUE) && (cnt_q >= MIN_LEN_W);
    assign filter_pass = promisc || (da_q == MAC_ADDR) || (da_q == 48'hFFFF_FFFF_FFFF)
                         || (accept_mcast && da_q[40]);
    assign slot_free   = !desc_vld_q || desc_rdy;

    assign do_commit   = do_eval && frame_good && filter_pass && slot_free;
    // An abandon without a restart is the DROP-state eof; a restart rewinds wptr itself.
    assign do_rollback = (do_eval && !do_commit) || (do_abandon && !do_start);
    assign crc_inc     = do_eval && !frame_good;
    assign drop_inc    = do_abandon || (do_eval && frame_good && filter_pass && !slot_free);

    // State register
    always_ff @(posedge rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (sof) state_d = ST_RECV;
            ST_RECV: begin
                if (sof)                       state_d = ST_RECV;
                else if (eof)                  state_d = ST_IDLE;
                else if (byte_vld && overflow) state_d = ST_DROP;
            end
            ST_DROP: begin
                if (sof)      state_d = ST_RECV;
                else if (eof) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Action decode
    always_comb begin
        do_start   = 1'b0;
        do_write   = 1'b0;
        do_eval    = 1'b0;
        do_abandon = 1'b0;
        case (state_q)
            ST_IDLE: do_start = sof;
            ST_RECV: begin
                if (sof) begin
                    do_abandon = 1'b1;
                    do_start   = 1'b1;
                end else if (eof) begin
                    do_eval = 1'b1;
                end else if (byte_vld && !overflow) begin
                    do_write = 1'b1;
                end
            end
            ST_DROP: begin
                if (sof) begin
                    do_abandon = 1'b1;
                    do_start   = 1'b1;
                end else if (eof) begin
                    do_abandon = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Datapath, descriptor and counters
    always_ff @(posedge rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            cptr_q        <= '0;
            wptr_q        <= '0;
            cnt_q         <= '0;
            crc_q         <= 32'hFFFF_FFFF;
            da_q          <= '0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            desc_vld_q    <= 1'b0;
            desc_start_q  <= '0;
            desc_len_q    <= '0;
            ok_cnt_q      <= '0;
            crc_err_cnt_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            wr_en_q <= do_write;
            if (do_write) begin
                wr_addr_q <= wptr_q;
                wr_data_q <= byte_data;
            end

            if (do_start) begin
                wptr_q <= cptr_q;
                cnt_q  <= '0;
                crc_q  <= 32'hFFFF_FFFF;
            end else if (do_write) begin
                wptr_q <= wptr_q + PTR_ONE;
                cnt_q  <= cnt_q + 16'd1;
                crc_q  <= crc_byte(crc_q, byte_data);
                // Shifting in the first six bytes leaves wire byte 0 in da_q[47:40].
                if (cnt_q < 16'd6) da_q <= {da_q[39:0], byte_data};
            end else if (do_commit) begin
                cptr_q <= wptr_q;
            end else if (do_rollback) begin
                wptr_q <= cptr_q;
            end

            if (do_commit) begin
                desc_vld_q   <= 1'b1;
                desc_start_q <= cptr_q;
                desc_len_q   <= cnt_q - 16'd4;
            end else if (desc_vld_q && desc_rdy) begin
                desc_vld_q   <= 1'b0;
            end

            if (do_commit) ok_cnt_q      <= sat_inc(ok_cnt_q);
            if (crc_inc)   crc_err_cnt_q <= sat_inc(crc_err_cnt_q);
            if (drop_inc)  drop_cnt_q    <= sat_inc(drop_cnt_q);
        end
    end

    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign desc_vld    = desc_vld_q;
    assign desc_start  = desc_start_q;
    assign desc_len    = desc_len_q;
    assign ok_cnt      = ok_cnt_q;
    assign crc_err_cnt = crc_err_cnt_q;
    assign drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_mac_rx_frame_ctrl.sv
// tb/tb_mac_rx_frame_ctrl.sv - directed self-checking bench for mac_rx_frame_ctrl
module tb_mac_rx_frame_ctrl;

    logic        rx_clk = 1'b0;
    always #4 rx_clk = ~rx_clk;

    logic        rst_n, byte_vld, sof, eof, promisc, accept_mcast, desc_rdy;
    logic [7:0]  byte_data;
    logic [10:0] rd_ptr;
    logic [6:0]  rd_ptr7;

    logic        wr_en, desc_vld;
    logic [10:0] wr_addr, desc_start;
    logic [7:0]  wr_data;
    logic [15:0] desc_len, ok_cnt, crc_err_cnt, drop_cnt;

    logic        wr_en7, desc_vld7;
    logic [6:0]  wr_addr7, desc_start7;
    logic [7:0]  wr_data7;
    logic [15:0] desc_len7, ok_cnt7, crc_err_cnt7, drop_cnt7;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0]  frame_q[$];
    logic [10:0] wr_addr_log[$];
    logic [7:0]  wr_data_log[$];
    int          wr7_cnt = 0;

    mac_rx_frame_ctrl dut (
        .rx_clk(rx_clk), .rst_n(rst_n), .byte_vld(byte_vld), .byte_data(byte_data),
        .sof(sof), .eof(eof), .promisc(promisc), .accept_mcast(accept_mcast),
        .rd_ptr(rd_ptr), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .desc_vld(desc_vld), .desc_rdy(desc_rdy), .desc_start(desc_start),
        .desc_len(desc_len), .ok_cnt(ok_cnt), .crc_err_cnt(crc_err_cnt), .drop_cnt(drop_cnt)
    );

    mac_rx_frame_ctrl #(.ADDR_W(7)) dut7 (
        .rx_clk(rx_clk), .rst_n(rst_n), .byte_vld(byte_vld), .byte_data(byte_data),
        .sof(sof), .eof(eof), .promisc(promisc), .accept_mcast(accept_mcast),
        .rd_ptr(rd_ptr7), .wr_en(wr_en7), .wr_addr(wr_addr7), .wr_data(wr_data7),
        .desc_vld(desc_vld7), .desc_rdy(desc_rdy), .desc_start(desc_start7),
        .desc_len(desc_len7), .ok_cnt(ok_cnt7), .crc_err_cnt(crc_err_cnt7), .drop_cnt(drop_cnt7)
    );

    always @(negedge rx_clk) begin
        if (wr_en) begin
            wr_addr_log.push_back(wr_addr);
            wr_data_log.push_back(wr_data);
        end
        if (wr_en7) wr7_cnt++;
    end

    task automatic tick();
        @(posedge rx_clk);
        #1;
    endtask

    task automatic do_reset();
        sof = 0; eof = 0; byte_vld = 0; byte_data = 0;
        promisc = 0; accept_mcast = 0; rd_ptr = 0; rd_ptr7 = 0; desc_rdy = 1;
        rst_n = 0;
        tick(); tick();
        rst_n = 1;
        tick();
    endtask

    // DA, fixed SA, counting payload, FCS appended LSB-first; optional flip of last FCS bit.
    task automatic build_frame(input logic [47:0] da, input int len, input logic corrupt);
        logic [31:0] crc;
        logic [7:0]  b;
        logic        fb;
        frame_q.delete();
        for (int i = 0; i < 6; i++) frame_q.push_back(da[47-8*i -: 8]);
        for (int i = 0; i < 6; i++) frame_q.push_back((i == 0) ? 8'h02 : ((i == 5) ? 8'h42 : 8'h00));
        for (int i = 12; i < len - 4; i++) frame_q.push_back(8'(i * 7 + 3));
        crc = 32'hFFFF_FFFF;
        foreach (frame_q[k]) begin
            b = frame_q[k];
            for (int j = 0; j < 8; j++) begin
                fb  = crc[0] ^ b[j];
                crc = crc >> 1;
                if (fb) crc = crc ^ 32'hEDB8_8320;
            end
        end
        crc = ~crc;
        for (int j = 0; j < 4; j++) frame_q.push_back(crc[8*j +: 8]);
        if (corrupt) frame_q[len-1] = frame_q[len-1] ^ 8'h01;
    endtask

    task automatic pulse_sof();
        sof = 1; tick(); sof = 0;
    endtask

    task automatic pulse_eof();
        eof = 1; tick(); eof = 0;
    endtask

    task automatic send_bytes(input int n);
        for (int i = 0; i < n; i++) begin
            byte_vld = 1; byte_data = frame_q[i];
            tick();
        end
        byte_vld = 0;
    endtask

    task automatic send_frame();
        pulse_sof();
        send_bytes(frame_q.size());
        pulse_eof();
    endtask

    task automatic test_reset();
        do_reset();
        vectors++; if (wr_en !== 1'b0)        begin miscompares++; $display("FAIL rst_wr_en: got %0b want 0", wr_en); end
        vectors++; if (wr_addr !== 11'd0)     begin miscompares++; $display("FAIL rst_wr_addr: got %0d want 0", wr_addr); end
        vectors++; if (wr_data !== 8'd0)      begin miscompares++; $display("FAIL rst_wr_data: got %0d want 0", wr_data); end
        vectors++; if (desc_vld !== 1'b0)     begin miscompares++; $display("FAIL rst_desc_vld: got %0b want 0", desc_vld); end
        vectors++; if (desc_start !== 11'd0)  begin miscompares++; $display("FAIL rst_desc_start: got %0d want 0", desc_start); end
        vectors++; if (desc_len !== 16'd0)    begin miscompares++; $display("FAIL rst_desc_len: got %0d want 0", desc_len); end
        vectors++; if ({ok_cnt, crc_err_cnt, drop_cnt} !== 48'd0) begin miscompares++;
            $display("FAIL rst_counters: got %0d/%0d/%0d want 0/0/0", ok_cnt, crc_err_cnt, drop_cnt); end
    endtask

    task automatic test_broadcast();
        int base, bad;
        do_reset();
        build_frame(48'hFFFF_FFFF_FFFF, 64, 1'b0);
        base = wr_addr_log.size();
        pulse_sof();
        send_bytes(64);
        eof = 1;
        vectors++; if (desc_vld !== 1'b0) begin miscompares++; $display("FAIL bcast_vld_early: got %0b want 0", desc_vld); end
        tick();
        eof = 0;
        vectors++; if (desc_vld !== 1'b1)     begin miscompares++; $display("FAIL bcast_desc_vld: got %0b want 1", desc_vld); end
        vectors++; if (desc_start !== 11'd0)  begin miscompares++; $display("FAIL bcast_desc_start: got %0d want 0", desc_start); end
        vectors++; if (desc_len !== 16'd60)   begin miscompares++; $display("FAIL bcast_desc_len: got %0d want 60", desc_len); end
        vectors++; if (ok_cnt !== 16'd1)      begin miscompares++; $display("FAIL bcast_ok_cnt: got %0d want 1", ok_cnt); end
        vectors++; if (wr_addr_log.size() - base !== 64) begin miscompares++;
            $display("FAIL bcast_wr_count: got %0d want 64", wr_addr_log.size() - base); end
        bad = 0;
        for (int i = 0; i < 64 && base + i < wr_addr_log.size(); i++)
            if (wr_addr_log[base+i] !== 11'(i) || wr_data_log[base+i] !== frame_q[i]) bad++;
        vectors++; if (bad !== 0) begin miscompares++; $display("FAIL bcast_wr_seq: got %0d bad writes want 0", bad); end
    endtask

    task automatic test_crc_error();
        do_reset();
        build_frame(48'hFFFF_FFFF_FFFF, 64, 1'b1);
        send_frame();
        vectors++; if (desc_vld !== 1'b0)      begin miscompares++; $display("FAIL crc_desc_vld: got %0b want 0", desc_vld); end
        vectors++; if (crc_err_cnt !== 16'd1)  begin miscompares++; $display("FAIL crc_err_cnt: got %0d want 1", crc_err_cnt); end
        build_frame(48'hFFFF_FFFF_FFFF, 64, 1'b0);
        send_frame();
        vectors++; if (desc_vld !== 1'b1 || desc_start !== 11'd0) begin miscompares++;
            $display("FAIL crc_next_start: got vld=%0b start=%0d want vld=1 start=0", desc_vld, desc_start); end
    endtask

    task automatic test_length();
        do_reset();
        build_frame(48'hFFFF_FFFF_FFFF, 63, 1'b0);
        send_frame();
        vectors++; if (crc_err_cnt !== 16'd1 || desc_vld !== 1'b0) begin miscompares++;
            $display("FAIL len_runt: got crc_err=%0d vld=%0b want 1/0", crc_err_cnt, desc_vld); end
        build_frame(48'hFFFF_FFFF_FFFF, 1518, 1'b0);
        send_frame();
        vectors++; if (desc_vld !== 1'b1 || desc_len !== 16'd1514 || desc_start !== 11'd0) begin miscompares++;
            $display("FAIL len_max: got vld=%0b len=%0d start=%0d want 1/1514/0", desc_vld, desc_len, desc_start); end
    endtask

    task automatic test_oversize();
        int base;
        do_reset();
        build_frame(48'hFFFF_FFFF_FFFF, 1519, 1'b0);
        base = wr_addr_log.size();
        send_frame();
        vectors++; if (drop_cnt !== 16'd1)  begin miscompares++; $display("FAIL over_drop_cnt: got %0d want 1", drop_cnt); end
        vectors++; if (desc_vld !== 1'b0 || ok_cnt !== 16'd0) begin miscompares++;
            $display("FAIL over_no_desc: got vld=%0b ok=%0d want 0/0", desc_vld, ok_cnt); end
        vectors++; if (wr_addr_log.size() - base !== 1518) begin miscompares++;
            $display("FAIL over_wr_count: got %0d want 1518", wr_addr_log.size() - base); end
    endtask

    task automatic test_filter();
        do_reset();
        build_frame(48'h02_00_00_00_00_99, 64, 1'b0);
        send_frame();
        vectors++; if (desc_vld !== 1'b0 || {ok_cnt, crc_err_cnt, drop_cnt} !== 48'd0) begin miscompares++;
            $display("FAIL filt_reject: got vld=%0b cnts=%0d/%0d/%0d want 0 0/0/0", desc_vld, ok_cnt, crc_err_cnt, drop_cnt); end
        promisc = 1;
        send_frame();
        promisc = 0;
        vectors++; if (ok_cnt !== 16'd1 || desc_len !== 16'd60) begin miscompares++;
            $display("FAIL filt_promisc: got ok=%0d len=%0d want 1/60", ok_cnt, desc_len); end
        build_frame(48'h01_00_5E_00_00_01, 64, 1'b0);
        send_frame();
        vectors++; if (ok_cnt !== 16'd1) begin miscompares++; $display("FAIL filt_mcast_off: got %0d want 1", ok_cnt); end
        accept_mcast = 1;
        send_frame();
        accept_mcast = 0;
        vectors++; if (ok_cnt !== 16'd2) begin miscompares++; $display("FAIL filt_mcast_on: got %0d want 2", ok_cnt); end
        build_frame(48'h02_00_00_00_00_01, 64, 1'b0);
        send_frame();
        vectors++; if (ok_cnt !== 16'd3 || desc_start !== 11'd128) begin miscompares++;
            $display("FAIL filt_own: got ok=%0d start=%0d want 3/128", ok_cnt, desc_start); end
    endtask

    task automatic test_overrun();
        int base;
        do_reset();
        build_frame(48'hFFFF_FFFF_FFFF, 64, 1'b0);
        send_frame();
        vectors++; if (desc_vld7 !== 1'b1 || desc_start7 !== 7'd0) begin miscompares++;
            $display("FAIL ovr_first: got vld=%0b start=%0d want 1/0", desc_vld7, desc_start7); end
        base = wr7_cnt;
        send_frame();
        vectors++; if (drop_cnt7 !== 16'd1 || desc_vld7 !== 1'b0) begin miscompares++;
            $display("FAIL ovr_drop: got drop=%0d vld=%0b want 1/0", drop_cnt7, desc_vld7); end
        vectors++; if (wr7_cnt - base !== 63) begin miscompares++; $display("FAIL ovr_wr_count: got %0d want 63", wr7_cnt - base); end
        rd_ptr7 = 7'd64;
        send_frame();
        vectors++; if (desc_vld7 !== 1'b1 || desc_start7 !== 7'd64 || ok_cnt7 !== 16'd2) begin miscompares++;
            $display("FAIL ovr_third: got vld=%0b start=%0d ok=%0d want 1/64/2", desc_vld7, desc_start7, ok_cnt7); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        desc_rdy = 0;
        build_frame(48'hFFFF_FFFF_FFFF, 64, 1'b0);
        send_frame();
        send_frame();
        vectors++; if (drop_cnt !== 16'd1 || ok_cnt !== 16'd1) begin miscompares++;
            $display("FAIL b2b_busy_cnts: got drop=%0d ok=%0d want 1/1", drop_cnt, ok_cnt); end
        vectors++; if (desc_vld !== 1'b1 || desc_start !== 11'd0 || desc_len !== 16'd60) begin miscompares++;
            $display("FAIL b2b_held: got vld=%0b start=%0d len=%0d want 1/0/60", desc_vld, desc_start, desc_len); end
        do_reset();
        desc_rdy = 0;
        send_frame();
        pulse_sof();
        send_bytes(64);
        desc_rdy = 1;
        pulse_eof();
        vectors++; if (desc_vld !== 1'b1 || desc_start !== 11'd64 || ok_cnt !== 16'd2 || drop_cnt !== 16'd0) begin miscompares++;
            $display("FAIL b2b_swap: got vld=%0b start=%0d ok=%0d drop=%0d want 1/64/2/0", desc_vld, desc_start, ok_cnt, drop_cnt); end
    endtask

    task automatic test_sof_restart();
        int base;
        do_reset();
        build_frame(48'hFFFF_FFFF_FFFF, 64, 1'b0);
        base = wr_addr_log.size();
        pulse_sof();
        send_bytes(20);
        send_frame();
        vectors++; if (drop_cnt !== 16'd1 || ok_cnt !== 16'd1) begin miscompares++;
            $display("FAIL restart_cnts: got drop=%0d ok=%0d want 1/1", drop_cnt, ok_cnt); end
        vectors++; if (desc_start !== 11'd0 || desc_vld !== 1'b1) begin miscompares++;
            $display("FAIL restart_desc: got vld=%0b start=%0d want 1/0", desc_vld, desc_start); end
        vectors++; if (wr_addr_log.size() <= base + 20 || wr_addr_log[base+20] !== 11'd0) begin miscompares++;
            $display("FAIL restart_rewind: got %0d want 0", (wr_addr_log.size() > base + 20) ? wr_addr_log[base+20] : 11'h7FF); end
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        desc_rdy = 0;
        build_frame(48'hFFFF_FFFF_FFFF, 64, 1'b0);
        send_frame();
        pulse_sof();
        send_bytes(30);
        rst_n = 0;
        #1;
        vectors++; if (wr_en !== 1'b0 || wr_addr !== 11'd0 || wr_data !== 8'd0) begin miscompares++;
            $display("FAIL mid_rst_wr: got en=%0b addr=%0d data=%0d want 0/0/0", wr_en, wr_addr, wr_data); end
        vectors++; if (desc_vld !== 1'b0 || desc_len !== 16'd0 || ok_cnt !== 16'd0) begin miscompares++;
            $display("FAIL mid_rst_desc: got vld=%0b len=%0d ok=%0d want 0/0/0", desc_vld, desc_len, ok_cnt); end
        tick();
        rst_n = 1;
        desc_rdy = 1;
        tick();
        send_frame();
        vectors++; if (desc_vld !== 1'b1 || desc_start !== 11'd0 || ok_cnt !== 16'd1) begin miscompares++;
            $display("FAIL mid_rst_after: got vld=%0b start=%0d ok=%0d want 1/0/1", desc_vld, desc_start, ok_cnt); end
    endtask

    initial begin
        test_reset();
        test_broadcast();
        test_crc_error();
        test_length();
        test_oversize();
        test_filter();
        test_overrun();
        test_back_to_back();
        test_sof_restart();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
